// File: rtl/em_skid_buffer_if.sv
// Execute->Memory handshake bundle for em_skid_buffer.
// Handshake rule: a transfer happens on a rising clk edge exactly when
// valid and ready are both high in that cycle; valid never waits on ready,
// and a producer holding valid keeps its payload stable until the transfer.
// The slave modport is the buffer; the master modport is the surroundings
// (Execute stage, hazard unit and Memory stage together).
interface em_skid_buffer_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  // upstream (Execute) side
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] controlSignals_in;
  logic [DATA_W-1:0] ALUData_in;
  logic [DATA_W-1:0] ReadData2_in;
  logic [ADDR_W-1:0] WriteAdd_in;
  // hazard unit
  logic              flush;
  // downstream (Memory) side
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] controlSignals_out;
  logic [DATA_W-1:0] ALUData_out;
  logic [DATA_W-1:0] ReadData2_out;
  logic [ADDR_W-1:0] WriteAdd_out;
  // observability
  logic [CNT_W-1:0]  stall_cycles;
  logic [1:0]        dbg_state;

  modport slave (
    input  in_valid, controlSignals_in, ALUData_in, ReadData2_in, WriteAdd_in,
    input  flush, out_ready,
    output in_ready, out_valid, controlSignals_out, ALUData_out,
    output ReadData2_out, WriteAdd_out, stall_cycles, dbg_state
  );

  modport master (
    output in_valid, controlSignals_in, ALUData_in, ReadData2_in, WriteAdd_in,
    output flush, out_ready,
    input  in_ready, out_valid, controlSignals_out, ALUData_out,
    input  ReadData2_out, WriteAdd_out, stall_cycles, dbg_state
  );
endinterface

// File: rtl/em_skid_buffer.sv
// Execute->Memory pipeline register with a 2-entry skid (main + skid).
// The main entry always drives the outputs; the skid entry catches the one
// instruction that arrives while Memory is stalled, so in_ready can be a
// pure register output and no instruction is ever dropped or duplicated.
// State is the pair {main_v, skid_v}: EMPTY=00, ONE=10, TWO=11, exposed on
// dbg_state.
// Optional build macro EM_BUF_STALL_CNT_EN: when defined, stall_cycles counts
// cycles with out_valid=1 and out_ready=0 (saturating, cleared by rst only);
// when undefined, stall_cycles is tied to zero.
module em_skid_buffer #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  em_skid_buffer_if.slave  bus
);

  localparam int PAY_W = CTRL_W + 2 * DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PAY_W-1:0]  main_q;
  logic [PAY_W-1:0]  skid_q;
  logic [PAY_W-1:0]  in_pay;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_v;
  logic              skid_v;
  logic              acc;
  logic              dep;
  logic              main_ld_in;
  logic              main_ld_skid;
  logic              skid_ld;

  // The valid bits are the state encoding itself.
  assign main_v = state_q[1];
  assign skid_v = state_q[0];

  assign in_pay = {bus.controlSignals_in, bus.ALUData_in,
                   bus.ReadData2_in, bus.WriteAdd_in};

  // in_ready depends only on registered state and rst, never on out_ready.
  assign bus.in_ready  = ~skid_v & ~rst;
  assign bus.out_valid = main_v;
  assign acc           = bus.in_valid & bus.in_ready;
  assign dep           = main_v & bus.out_ready;

  // Next state and payload load enables; flush empties both entries and
  // drops any instruction accepted in the same cycle.
  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_ld_in = 1'b1;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (acc && dep) begin
            main_ld_in = 1'b1;
          end else if (acc) begin
            skid_ld = 1'b1;
            state_d = TWO;
          end else if (dep) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // skid is always the younger entry, so it moves up on departure
          if (dep) begin
            main_ld_skid = 1'b1;
            state_d      = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State register; rst wins over flush and everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers load only on accept/refill events and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld_in) begin
        main_q <= in_pay;
      end else if (main_ld_skid) begin
        main_q <= skid_q;
      end
      if (skid_ld) begin
        skid_q <= in_pay;
      end
    end
  end

  assign {main_ctrl, bus.ALUData_out, bus.ReadData2_out, bus.WriteAdd_out} = main_q;

  // A bubble must not carry any write or memory enable downstream.
  assign bus.controlSignals_out = main_v ? main_ctrl : '0;

  assign bus.dbg_state = state_q;

`ifdef EM_BUF_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Count back-pressured cycles, saturating; flush deliberately leaves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_v && !bus.out_ready && !(&stall_q)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/em_skid_buffer.md
Name: em_skid_buffer

Overview:
- Parametrised Execute→Memory pipeline register with a valid/ready handshake and a 2-entry skid, replacing the fixed-width, always-load E/M register.
- Carries control, ALU result, store data and write-back register address.
- Adds backpressure from the Memory stage, flush from the hazard unit, and zero-control bubbles, so stalls never drop or duplicate an instruction.

Parameters:
CTRL_W, 8, control-signal bundle width
DATA_W, 16, width of ALU result and store data
ADDR_W, 3, register-file write address width
CNT_W, 16, stall counter width (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  Execute stage presents a valid instruction
in_ready  out  1  buffer can accept this cycle
controlSignals_in  in  CTRL_W  control bundle from Execute
ALUData_in  in  DATA_W  ALU result
ReadData2_in  in  DATA_W  store data
WriteAdd_in  in  ADDR_W  write-back register address
flush  in  1  discard all held instructions
out_valid  out  1  Memory stage sees a valid instruction
out_ready  in  1  Memory stage consumes this cycle
controlSignals_out  out  CTRL_W  control to Memory; all-zero when out_valid=0
ALUData_out  out  DATA_W  held ALU result
ReadData2_out  out  DATA_W  held store data
WriteAdd_out  out  ADDR_W  held write address
stall_cycles  out  CNT_W  back-pressure cycle count

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Storage:
  - main entry: payload plus main_v; drives all outputs.
  - skid entry: payload plus skid_v.
- Handshake signals:
  - out_valid = main_v.
  - in_ready = ~skid_v & ~rst (combinational from registered state).
  - acc = in_valid & in_ready; dep = out_valid & out_ready.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1. Throughput is 1/cycle while out_ready=1.
- States, as {main_v, skid_v}:
  - EMPTY 00:
    - acc → main loads input → ONE.
    - no acc → stay.
  - ONE 10:
    - acc & dep → main loads input → ONE.
    - acc & ~dep → skid loads input → TWO.
    - ~acc & dep → EMPTY.
    - neither → hold.
  - TWO 11 (in_ready=0):
    - dep → main loads skid, skid_v clears → ONE.
    - else hold.
- Ordering: strictly FIFO; skid contents always younger than main.
- Payload registers load only on the listed events; otherwise they hold. No combinational path from the *_in ports to the *_out ports.
- controlSignals_out = main_v ? main_ctrl : 0, so a bubble asserts no write or memory enable.
- flush:
  - Next cycle main_v=0 and skid_v=0 (state EMPTY).
  - Overrides a simultaneous acc: the input is dropped.
  - A dep in the flush cycle is still a completed transfer for the Memory stage.
- rst:
  - Next cycle main_v=skid_v=0.
  - All payload registers and controlSignals_out read 0; out_valid=0; in_ready=0 while rst=1, then 1.
  - Reset mid-transfer discards both entries.
  - rst has priority over flush.
- Holding with out_valid=1 and out_ready=0 keeps all outputs stable.

Optional Feature:
EM_BUF_STALL_CNT_EN
- Defined:
  - stall_cycles increments each cycle with out_valid=1 & out_ready=0, saturating at 2^CNT_W-1.
  - Cleared by rst only; flush does not clear it.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Reset then stream: rst 2 cycles; in_valid=1, out_ready=1, ALUData_in 0x0001..0x0004 → outputs 0x0001..0x0004 on consecutive cycles, one cycle after each accept; in_ready stays 1.
- Back-pressure skid: out_ready=0, feed ALUData_in 0x00A0 then 0x00B0 → in_ready falls after second accept; out holds 0x00A0. Raise out_ready → 0x00A0, then 0x00B0; nothing lost or duplicated.
- Flush with incoming: state TWO with 0x0011/0x0022, flush=1 with in_valid=1 data 0x0033 → next cycle out_valid=0, controlSignals_out=0x00, in_ready=1; 0x0033 never appears.
- Bubble control: controlSignals_in=0xFF accepted, then in_valid=0 with out_ready=1 → 0xFF for one cycle, then 0x00 with out_valid=0.
- Reset mid-operation: state TWO, rst=1 with in_valid=1 → next cycle all outputs 0 and in_ready=0; after rst drops, in_ready=1 and a new accept of WriteAdd_in=3'd5 appears on WriteAdd_out.
- Counter (macro defined, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles → stall_cycles=15 (saturated); flush leaves 15; rst returns 0. Macro undefined → stall_cycles stays 0.
